// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the mcu_core slice.
//   - opcode_e : 5-bit instruction opcodes (IR[17:13])
//   - state_e  : fetch/execute/interrupt sequencer states
//   - IR field slice positions and a zero-detect helper used for the Z flag
package mcu_pkg;

    typedef enum logic [4:0] {
        OP_ADD_R = 5'h00, OP_ADD_I = 5'h01,
        OP_SUB_R = 5'h02, OP_SUB_I = 5'h03,
        OP_AND_R = 5'h04, OP_AND_I = 5'h05,
        OP_OR_R  = 5'h06, OP_OR_I  = 5'h07,
        OP_XOR_R = 5'h08, OP_XOR_I = 5'h09,
        OP_MOV_R = 5'h0A, OP_MOV_I = 5'h0B,
        OP_IN    = 5'h0C, OP_OUT   = 5'h0D,
        OP_BRN   = 5'h0E, OP_BREQ  = 5'h0F,
        OP_BRNE  = 5'h10, OP_BRCS  = 5'h11,
        OP_BRCC  = 5'h12, OP_CALL  = 5'h13,
        OP_RET   = 5'h14, OP_SEI   = 5'h15,
        OP_CLI   = 5'h16, OP_RETIE = 5'h17,
        OP_SEC   = 5'h18, OP_CLC   = 5'h19,
        OP_CMP_R = 5'h1A, OP_CMP_I = 5'h1B
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_INTR  = 2'd2
    } state_e;

    localparam int IR_W    = 18;
    localparam int OPC_HI  = 17;
    localparam int OPC_LO  = 13;
    localparam int RX_HI   = 12;
    localparam int RX_LO   = 8;
    localparam int RY_HI   = 7;
    localparam int RY_LO   = 3;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;
    localparam int ADDR_HI = 12;
    localparam int ADDR_LO = 3;

    function automatic logic is_zero(input logic [7:0] v);
        return (v == 8'h00);
    endfunction

endpackage

// File: rtl/mcu_call_stack.sv
// mcu_call_stack: circular return-address stack.
//   CLK, RESET_N : clock, async active-low reset
//   push, pop    : one-cycle requests (push wins if both are raised)
//   din          : address written on push
//   dout         : top-of-stack address, valid combinationally for pop
//   err          : sticky overflow/underflow flag, cleared only by reset
// Overflow overwrites the oldest entry; underflow returns whatever is in
// the slot below the pointer. Both simply wrap the pointer.
module mcu_call_stack #(
    parameter int PCW         = 10,
    parameter int STACK_DEPTH = 8
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           push,
    input  logic           pop,
    input  logic [PCW-1:0] din,
    output logic [PCW-1:0] dout,
    output logic           err
);
    import mcu_pkg::*;

    localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW:0] FULL_CNT = (SPW + 1)'(STACK_DEPTH);

    logic [PCW-1:0] mem_q [STACK_DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW:0]   cnt_q;
    logic           err_q;
    logic [SPW-1:0] sp_m1_s;

    assign sp_m1_s = sp_q - SPW'(1);
    assign dout    = mem_q[sp_m1_s];
    assign err     = err_q;

    // Entry storage: written at the current pointer on push, never reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[sp_q] <= din;
        end
    end

    // Pointer, occupancy and sticky error tracking.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (push) begin
            sp_q <= sp_q + SPW'(1);
            if (cnt_q == FULL_CNT) begin
                err_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + (SPW + 1)'(1);
            end
        end else if (pop) begin
            sp_q <= sp_m1_s;
            if (cnt_q == '0) begin
                err_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - (SPW + 1)'(1);
            end
        end else begin
            sp_q <= sp_q;
        end
    end

endmodule

// File: rtl/mcu_core.sv
// mcu_core: 8-bit RAT-style microcontroller core.
//   CLK, RESET_N : clock, async active-low reset
//   prog_addr    : ROM address (= pc), prog_ir : ROM data, one cycle later
//   in_port      : IN data;  out_port/port_id/io_strb : OUT bus
//   intr         : level interrupt request; int_ack : taken pulse
//   stk_err      : sticky call-stack overflow/underflow
// Each instruction takes FETCH then EXEC; a taken interrupt adds INTR.
module mcu_core
    import mcu_pkg::*;
#(
    parameter int         PCW         = 10,
    parameter int         STACK_DEPTH = 8,
    parameter logic [9:0] INT_VEC     = 10'h3FF,
    parameter int         DW          = 8
) (
    input  logic            CLK,
    input  logic            RESET_N,
    output logic [PCW-1:0]  prog_addr,
    input  logic [17:0]     prog_ir,
    input  logic [DW-1:0]   in_port,
    output logic [DW-1:0]   out_port,
    output logic [7:0]      port_id,
    output logic            io_strb,
    input  logic            intr,
    output logic            int_ack,
    output logic            stk_err
);
    localparam logic [PCW-1:0] INT_VEC_PC = INT_VEC[PCW-1:0];

    state_e         state_q;
    logic [PCW-1:0] pc_q, pc_d;
    logic           c_q, c_d, z_q, z_d, ie_q, ie_d;
    logic           sc_q, sz_q, int_ack_q;
    logic [DW-1:0]  rf_q [32];

    opcode_e        op_s;
    logic [4:0]     rx_s, ry_s;
    logic [DW-1:0]  imm_s, a_s, b_s, rf_wdata_s;
    logic [9:0]     addr_s;
    logic [PCW-1:0] br_pc_s, pc_inc_s, stk_din_s, stk_dout_s;
    logic [DW:0]    sum_s, diff_s;
    logic           rf_we_s, push_s, pop_s, take_int_s;

    assign op_s    = opcode_e'(prog_ir[OPC_HI:OPC_LO]);
    assign rx_s    = prog_ir[RX_HI:RX_LO];
    assign ry_s    = prog_ir[RY_HI:RY_LO];
    assign imm_s   = prog_ir[IMM_HI:IMM_LO];
    assign addr_s  = prog_ir[ADDR_HI:ADDR_LO];
    assign br_pc_s = addr_s[PCW-1:0];

    // Odd ALU opcodes take the immediate as second operand.
    assign a_s      = rf_q[rx_s];
    assign b_s      = prog_ir[OPC_LO] ? imm_s : rf_q[ry_s];
    assign sum_s    = {1'b0, a_s} + {1'b0, b_s};
    assign diff_s   = {1'b0, a_s} - {1'b0, b_s};
    assign pc_inc_s = pc_q + PCW'(1);

    // INTR pushes pc, which already holds the next pc after EXEC.
    assign stk_din_s = (state_q == ST_INTR) ? pc_q : pc_inc_s;

    assign prog_addr = pc_q;
    assign int_ack   = int_ack_q;

    // Instruction decode / execute datapath for the EXEC cycle.
    always_comb begin
        pc_d       = pc_inc_s;
        c_d        = c_q;
        z_d        = z_q;
        ie_d       = ie_q;
        rf_we_s    = 1'b0;
        rf_wdata_s = b_s;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        io_strb    = 1'b0;
        port_id    = 8'h00;
        out_port   = '0;
        if (state_q == ST_EXEC) begin
            case (op_s)
                OP_ADD_R, OP_ADD_I: begin
                    rf_we_s = 1'b1; rf_wdata_s = sum_s[DW-1:0];
                    c_d = sum_s[DW]; z_d = is_zero(sum_s[DW-1:0]);
                end
                OP_SUB_R, OP_SUB_I: begin
                    rf_we_s = 1'b1; rf_wdata_s = diff_s[DW-1:0];
                    c_d = diff_s[DW]; z_d = is_zero(diff_s[DW-1:0]);
                end
                OP_CMP_R, OP_CMP_I: begin
                    c_d = diff_s[DW]; z_d = is_zero(diff_s[DW-1:0]);
                end
                OP_AND_R, OP_AND_I: begin
                    rf_we_s = 1'b1; rf_wdata_s = a_s & b_s;
                    c_d = 1'b0; z_d = is_zero(a_s & b_s);
                end
                OP_OR_R, OP_OR_I: begin
                    rf_we_s = 1'b1; rf_wdata_s = a_s | b_s;
                    c_d = 1'b0; z_d = is_zero(a_s | b_s);
                end
                OP_XOR_R, OP_XOR_I: begin
                    rf_we_s = 1'b1; rf_wdata_s = a_s ^ b_s;
                    c_d = 1'b0; z_d = is_zero(a_s ^ b_s);
                end
                OP_MOV_R, OP_MOV_I: begin
                    rf_we_s = 1'b1; rf_wdata_s = b_s;
                end
                OP_IN: begin
                    rf_we_s = 1'b1; rf_wdata_s = in_port; port_id = imm_s;
                end
                OP_OUT: begin
                    io_strb = 1'b1; port_id = imm_s; out_port = a_s;
                end
                OP_BRN:  pc_d = br_pc_s;
                OP_BREQ: pc_d = z_q  ? br_pc_s : pc_inc_s;
                OP_BRNE: pc_d = !z_q ? br_pc_s : pc_inc_s;
                OP_BRCS: pc_d = c_q  ? br_pc_s : pc_inc_s;
                OP_BRCC: pc_d = !c_q ? br_pc_s : pc_inc_s;
                OP_CALL: begin
                    push_s = 1'b1; pc_d = br_pc_s;
                end
                OP_RET: begin
                    pop_s = 1'b1; pc_d = stk_dout_s;
                end
                OP_RETIE: begin
                    pop_s = 1'b1; pc_d = stk_dout_s;
                    c_d = sc_q; z_d = sz_q; ie_d = 1'b1;
                end
                OP_SEI: ie_d = 1'b1;
                OP_CLI: ie_d = 1'b0;
                OP_SEC: c_d  = 1'b1;
                OP_CLC: c_d  = 1'b0;
                default: pc_d = pc_inc_s;
            endcase
        end else begin
            push_s = (state_q == ST_INTR);
        end
    end

    // SEI's new IE is not yet visible; CLI and RETIE take effect at once.
    assign take_int_s = intr & ((op_s == OP_SEI) ? ie_q : ie_d);

    // Sequencer: FETCH -> EXEC -> (INTR) -> FETCH, plus flags, IE and pc.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_FETCH;
            pc_q      <= '0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            ie_q      <= 1'b0;
            sc_q      <= 1'b0;
            sz_q      <= 1'b0;
            int_ack_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    state_q   <= ST_EXEC;
                    int_ack_q <= 1'b0;
                end
                ST_EXEC: begin
                    pc_q      <= pc_d;
                    c_q       <= c_d;
                    z_q       <= z_d;
                    ie_q      <= ie_d;
                    int_ack_q <= take_int_s;
                    state_q   <= take_int_s ? ST_INTR : ST_FETCH;
                end
                ST_INTR: begin
                    sc_q      <= c_q;
                    sz_q      <= z_q;
                    ie_q      <= 1'b0;
                    pc_q      <= INT_VEC_PC;
                    int_ack_q <= 1'b0;
                    state_q   <= ST_FETCH;
                end
                default: begin
                    state_q   <= ST_FETCH;
                    int_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Register file write port (contents intentionally not reset).
    always_ff @(posedge CLK) begin
        if (rf_we_s) begin
            rf_q[rx_s] <= rf_wdata_s;
        end
    end

    mcu_call_stack #(
        .PCW         (PCW),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (push_s),
        .pop     (pop_s),
        .din     (stk_din_s),
        .dout    (stk_dout_s),
        .err     (stk_err)
    );

endmodule

// File: tb/tb_mcu_core.sv
// tb_mcu_core: directed program in a synchronous-read ROM model. Expected
// OUT transactions {port_id, out_port, stk_err} are queued up front; a
// negedge monitor pops and compares whenever io_strb is seen.
module tb_mcu_core;
    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [9:0]  prog_addr;
    logic [17:0] prog_ir;
    logic [7:0]  in_port, out_port, port_id;
    logic        io_strb, intr, int_ack, stk_err;

    logic [17:0] rom [0:1023];
    logic [16:0] exp_q [$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, loop_cnt = 0, loop_t = 0, ack_cnt = 0;
    bit loop_arm = 1'b1, ack_prev = 1'b0;
    logic [9:0] last_pa = 10'h000;

    mcu_core #(.PCW(10), .STACK_DEPTH(8), .INT_VEC(10'h3FF), .DW(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .prog_addr(prog_addr), .prog_ir(prog_ir),
        .in_port(in_port), .out_port(out_port), .port_id(port_id),
        .io_strb(io_strb), .intr(intr), .int_ack(int_ack), .stk_err(stk_err)
    );

    always #5 CLK = ~CLK;

    // ROM with one-cycle synchronous read.
    always @(posedge CLK) prog_ir <= rom[prog_addr];

    function automatic logic [17:0] ri(input logic [4:0] op, input logic [4:0] rx, input logic [7:0] imm);
        return {op, rx, imm};
    endfunction
    function automatic logic [17:0] rr(input logic [4:0] op, input logic [4:0] rx, input logic [4:0] ry);
        return {op, rx, ry, 3'b000};
    endfunction
    function automatic logic [17:0] br(input logic [4:0] op, input logic [9:0] a);
        return {op, a, 3'b000};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    task automatic wait_addr(input logic [9:0] a, input int budget, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge CLK);
            if (prog_addr == a) hit = 1'b1;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: prog_addr never reached %h (now %h)", nm, a, prog_addr);
        end
    endtask

    // Monitor: scoreboard pops on io_strb, idle-bus, int_ack and loop timing checks.
    always @(negedge CLK) begin
        logic [16:0] e;
        cyc++;
        if (RESET_N) begin
            if (io_strb) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got port=%h data=%h err=%b, expected none", port_id, out_port, stk_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({port_id, out_port, stk_err} !== e) begin
                        n_fail++;
                        $display("FAIL out_txn: got port=%h data=%h err=%b, expected port=%h data=%h err=%b",
                                 port_id, out_port, stk_err, e[16:9], e[8:1], e[0]);
                    end
                end
            end else begin
                n_chk++;
                if (out_port !== 8'h00 || !(port_id === 8'h00 || port_id === 8'h77)) begin
                    n_fail++;
                    $display("FAIL idle_bus: got port=%h data=%h, expected 00/00", port_id, out_port);
                end
            end
            if (ack_prev) check("vector_fetch", {22'd0, prog_addr}, 32'h3FF);
            if (int_ack) ack_cnt++;
            ack_prev = int_ack;
            if (loop_arm && prog_addr == 10'h00E && last_pa != 10'h00E) begin
                if (loop_cnt > 0) check("loop_spacing", cyc - loop_t, 32'd4);
                loop_cnt++;
                loop_t = cyc;
            end
            last_pa = prog_addr;
        end
    end

    initial begin
        bit seen;
        RESET_N = 1'b0; intr = 1'b0; in_port = 8'h3E;
        for (int i = 0; i < 1024; i++) rom[i] = ri(5'h1F, 5'd0, 8'h00);
        rom[10'h000] = ri(5'h0B, 5'd1, 8'hF0);  rom[10'h001] = ri(5'h01, 5'd1, 8'h20);
        rom[10'h002] = ri(5'h0D, 5'd1, 8'h01);  rom[10'h003] = br(5'h11, 10'h005);
        rom[10'h004] = ri(5'h0D, 5'd0, 8'hEE);  rom[10'h005] = br(5'h10, 10'h007);
        rom[10'h006] = ri(5'h0D, 5'd0, 8'hEE);  rom[10'h007] = ri(5'h03, 5'd1, 8'h10);
        rom[10'h008] = ri(5'h0D, 5'd1, 8'h02);  rom[10'h009] = br(5'h0F, 10'h00B);
        rom[10'h00A] = ri(5'h0D, 5'd0, 8'hEE);  rom[10'h00B] = br(5'h12, 10'h00D);
        rom[10'h00C] = ri(5'h0D, 5'd0, 8'hEE);  rom[10'h00D] = ri(5'h0B, 5'd2, 8'h03);
        rom[10'h00E] = ri(5'h03, 5'd2, 8'h01);  rom[10'h00F] = br(5'h10, 10'h00E);
        rom[10'h010] = br(5'h13, 10'h050);      rom[10'h011] = ri(5'h0D, 5'd5, 8'h03);
        rom[10'h012] = ri(5'h0B, 5'd3, 8'hA5);  rom[10'h013] = ri(5'h0D, 5'd3, 8'h42);
        rom[10'h014] = ri(5'h15, 5'd0, 8'h00);  rom[10'h015] = ri(5'h18, 5'd0, 8'h00);
        rom[10'h016] = br(5'h11, 10'h018);      rom[10'h017] = ri(5'h0D, 5'd0, 8'hEE);
        rom[10'h018] = ri(5'h0D, 5'd3, 8'h04);  rom[10'h019] = ri(5'h0B, 5'd7, 8'h01);
        rom[10'h01A] = br(5'h11, 10'h01C);      rom[10'h01B] = ri(5'h0D, 5'd0, 8'hEE);
        rom[10'h01C] = ri(5'h0D, 5'd7, 8'h05);  rom[10'h01D] = ri(5'h0B, 5'd8, 8'h3C);
        rom[10'h01E] = ri(5'h05, 5'd8, 8'h0F);  rom[10'h01F] = ri(5'h07, 5'd8, 8'h50);
        rom[10'h020] = ri(5'h09, 5'd8, 8'hFF);  rom[10'h021] = ri(5'h0D, 5'd8, 8'h06);
        rom[10'h022] = ri(5'h0C, 5'd9, 8'h77);  rom[10'h023] = rr(5'h00, 5'd9, 5'd8);
        rom[10'h024] = ri(5'h0D, 5'd9, 8'h07);  rom[10'h025] = ri(5'h1B, 5'd9, 8'hE1);
        rom[10'h026] = br(5'h0F, 10'h028);      rom[10'h027] = ri(5'h0D, 5'd0, 8'hEE);
        rom[10'h028] = ri(5'h1B, 5'd9, 8'hF0);  rom[10'h029] = br(5'h11, 10'h02B);
        rom[10'h02A] = ri(5'h0D, 5'd0, 8'hEE);  rom[10'h02B] = rr(5'h02, 5'd9, 5'd8);
        rom[10'h02C] = ri(5'h0D, 5'd9, 8'h08);  rom[10'h02D] = rr(5'h0A, 5'd10, 5'd9);
        rom[10'h02E] = ri(5'h0D, 5'd10, 8'h09); rom[10'h02F] = ri(5'h0B, 5'd11, 8'h00);
        rom[10'h030] = br(5'h13, 10'h070);      rom[10'h031] = ri(5'h0D, 5'd0, 8'hEE);
        rom[10'h050] = ri(5'h0B, 5'd5, 8'h5A);  rom[10'h051] = ri(5'h14, 5'd0, 8'h00);
        rom[10'h060] = ri(5'h19, 5'd0, 8'h00);  rom[10'h061] = br(5'h12, 10'h063);
        rom[10'h062] = ri(5'h0D, 5'd0, 8'hEE);  rom[10'h063] = ri(5'h17, 5'd0, 8'h00);
        rom[10'h070] = ri(5'h01, 5'd11, 8'h01); rom[10'h071] = ri(5'h1B, 5'd11, 8'h09);
        rom[10'h072] = br(5'h0F, 10'h074);      rom[10'h073] = br(5'h13, 10'h070);
        rom[10'h074] = ri(5'h0D, 5'd11, 8'h0A); rom[10'h075] = ri(5'h0D, 5'd11, 8'h0B);
        rom[10'h3FF] = br(5'h0E, 10'h060);

        // Hand-computed OUT transactions in program order.
        exp_q.push_back({8'h01, 8'h10, 1'b0});  // ADD 0xF0+0x20
        exp_q.push_back({8'h02, 8'h00, 1'b0});  // SUB -> 0
        exp_q.push_back({8'h03, 8'h5A, 1'b0});  // after CALL/RET
        exp_q.push_back({8'h42, 8'hA5, 1'b0});  // OUT r3,0x42
        exp_q.push_back({8'h04, 8'hA5, 1'b0});  // after 1st interrupt, C restored
        exp_q.push_back({8'h05, 8'h01, 1'b0});  // after 2nd interrupt
        exp_q.push_back({8'h06, 8'hA3, 1'b0});  // AND/OR/EXOR chain
        exp_q.push_back({8'h07, 8'hE1, 1'b0});  // IN 0x3E + 0xA3
        exp_q.push_back({8'h08, 8'h3E, 1'b0});  // SUB reg
        exp_q.push_back({8'h09, 8'h3E, 1'b0});  // MOV reg
        exp_q.push_back({8'h0A, 8'h09, 1'b1});  // 9 nested CALLs overflow depth 8

        repeat (3) @(posedge CLK);
        #1;
        check("rst_prog_addr", {22'd0, prog_addr}, 32'h0);
        check("rst_io_strb", {31'd0, io_strb}, 32'h0);
        check("rst_port_id", {24'd0, port_id}, 32'h0);
        check("rst_out_port", {24'd0, out_port}, 32'h0);
        check("rst_int_ack", {31'd0, int_ack}, 32'h0);
        check("rst_stk_err", {31'd0, stk_err}, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;

        wait_addr(10'h015, 500, "irq1_arm");
        intr = 1'b1;
        wait_addr(10'h061, 500, "irq1_handler");
        intr = 1'b0;
        wait_addr(10'h019, 500, "irq2_arm");
        intr = 1'b1;
        wait_addr(10'h061, 500, "irq2_handler");
        intr = 1'b0;

        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge CLK);
            #1;
            if (io_strb && port_id == 8'h0B) seen = 1'b1;
        end
        check("final_out_seen", {31'd0, seen}, 32'h1);
        check("loop_passes", loop_cnt, 32'd3);
        check("int_ack_cycles", ack_cnt, 32'd2);
        check("queue_drained", exp_q.size(), 32'd0);
        loop_arm = 1'b0;

        // Asynchronous reset in the middle of the OUT 0x0B EXEC cycle.
        RESET_N = 1'b0;
        #1;
        check("mid_rst_prog_addr", {22'd0, prog_addr}, 32'h0);
        check("mid_rst_stk_err", {31'd0, stk_err}, 32'h0);
        check("mid_rst_io_strb", {31'd0, io_strb}, 32'h0);
        check("mid_rst_port_id", {24'd0, port_id}, 32'h0);
        check("mid_rst_out_port", {24'd0, out_port}, 32'h0);

        exp_q.push_back({8'h01, 8'h10, 1'b0});
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
        check("restart_out", exp_q.size(), 32'd0);
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
